otfc_conv_multi: RTL and testbench
==================================

// Module: otfc_conv_multi
// PURPOSE
//  Multi-channel, frame-based on-the-fly converter (OTFC) for radix-2 signed digits (rbr_pkg::signed_digit), MSD first.
//  Keeps Q and QM = Q - ulp per channel. Accepts one digit per channel per handshake.
//  Presents the final two's-complement fraction after DIGITS digits or in_last.
//  Sits between online arithmetic units and conventional-binary consumers. All channels advance in lockstep.
// PARAMETERS
//  WIDTH    16  fractional result bits; out_q/out_qm are WIDTH+1 bits (bit WIDTH = sign)
//  DIGITS   16  max digits per frame, 1..WIDTH
//  CHANNELS 4   parallel lanes sharing one handshake and counter
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     synchronous, active-high reset
//  clear      in   1                     synchronous frame abort (same effect as rst)
//  in_valid   in   1                     digit vector valid
//  in_ready   out  1                     converter can accept a digit vector
//  in_digit   in   CHANNELS x digit      one signed_digit per lane
//  in_last    in   1                     current digit ends the frame early
//  out_valid  out  1                     frame result valid
//  out_ready  in   1                     consumer takes the result
//  out_q      out  CHANNELS x (WIDTH+1)  Q per lane (live during ACCUM, final in HOLD)
//  out_qm     out  CHANNELS x (WIDTH+1)  QM per lane
//  out_count  out  $clog2(DIGITS+1)      digits accepted in the current frame
// BEHAVIOUR
//  - Digit value: plus&!minus=+1; !plus&minus=-1; both clear or both set = 0.
//  - Digit j (0-based) has weight 2^-(j+1) and sits at bit WIDTH-1-j.
//  - Frame init and reset values:
//      Q=0, QM={1'b1,WIDTH'b0} (=-1), count=0, state ACCUM,
//      in_ready=1, out_valid=0.
//  - Update on accept (in_valid&in_ready), b = 1<<(WIDTH-1-count):
//      +1: Q<=Q|b, QM<=Q
//      -1: Q<=QM|b, QM<=QM
//       0: Q<=Q, QM<=QM|b
//    count<=count+1.
//  - FSM ACCUM: in_ready=1, out_valid=0. An accept with in_last=1 or count==DIGITS-1 goes to HOLD.
//  - FSM HOLD: in_ready=0, out_valid=1; Q, QM and count are frozen.
//      out_valid&out_ready: re-init the registers and go to ACCUM next cycle.
//  - Latency: out_valid is high the cycle after the final digit is accepted. One bubble cycle per frame.
//  - in_last on the DIGITS-th digit is the same as natural termination, not an error.
//  - in_last=1 is ignored when in_valid=0. in_digit/in_last are don't-care when not accepted.
//  - out_valid stays high and the outputs stay stable under out_ready=0 for any number of cycles.
//  - rst or clear in any state or cycle: re-init next edge.
//      The concurrent input digit is discarded. A pending result is dropped with no out_valid pulse.
//      rst has priority over the handshakes.
//  - Arithmetic is exact. Q range is [-1+2^-WIDTH, 1-2^-WIDTH]. No overflow is possible.
// TESTING (WIDTH=4, DIGITS=4, CHANNELS=2 unless noted)
//  1. Lane0 digits +1,0,-1,+1 -> out_q=5'b00111, out_qm=5'b00110, out_count=4;
//     out_valid rises 1 cycle after the 4th accept.
//  2. Lane1 digits -1,-1,-1,-1 -> out_q=5'b10001, out_qm=5'b10000.
//     Lane0 all both-set -> out_q=5'b00000, out_qm=5'b11111.
//  3. Digits -1,-1 with in_last on the 2nd -> out_q=5'b10100, out_qm=5'b10000, out_count=2.
//     Later bits are 0; in_ready=0 while in HOLD.
//  4. Hold out_ready=0 for 10 cycles in HOLD -> out_valid and outputs stable, no digit accepted.
//     Then out_ready=1 -> next cycle in_ready=1, Q=0, QM=5'b10000.
//  5. After 2 digits, pulse clear with in_valid=1 -> digit discarded, count=0, Q=0, QM=5'b10000.
//     Repeat with rst -> same result, no out_valid pulse.
//  6. Random digit frames with random in_last and back-pressure, all lanes, WIDTH=16, DIGITS=12:
//     out_q equals sum(d_j*2^-(j+1)) scaled by 2^16, and out_qm = out_q - 2^(16-count) at every HOLD.

Source files
------------

// File: rtl/otfc_conv_multi.sv
// rtl/otfc_conv_multi.sv - multi-lane frame-based on-the-fly signed-digit to two's-complement converter
//
// Purpose: converts CHANNELS parallel streams of radix-2 signed digits (MSD first)
// into WIDTH-bit two's-complement fractions, keeping Q and QM = Q - ulp per lane.
// Ports:
//   clk, rst, clear          clock, sync active-high reset, sync frame abort
//   in_valid/in_ready        digit-vector handshake; in_digit one digit per lane
//   in_last                  accepted digit closes the frame early
//   out_valid/out_ready      frame-result handshake
//   out_q/out_qm             per-lane Q and QM, WIDTH+1 bits (MSB = sign)
//   out_count                digits accepted in the current frame

package rbr_pkg;
    typedef struct packed {
        logic plus;
        logic minus;
    } signed_digit;
endpackage

module otfc_conv_multi #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 16,
    parameter int CHANNELS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  rbr_pkg::signed_digit [CHANNELS-1:0]   in_digit,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [CHANNELS-1:0][WIDTH:0]          out_q,
    output logic [CHANNELS-1:0][WIDTH:0]          out_qm,
    output logic [$clog2(DIGITS+1)-1:0]           out_count
);

    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t state, state_next;

    logic [CHANNELS-1:0][WIDTH:0] q, qm, q_next, qm_next;
    logic [CW-1:0]                count;
    logic [WIDTH:0]               bit_mask;
    logic [31:0]                  shamt;
    logic                         accept, frame_done, reinit;

    localparam logic [WIDTH:0] QM_INIT = {1'b1, {WIDTH{1'b0}}};

    assign accept     = in_valid & in_ready;
    assign frame_done = accept & (in_last | (count == CW'(DIGITS - 1)));
    // Abort and result hand-off both restart the frame.
    assign reinit     = rst | clear | (out_valid & out_ready);

    // State register
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (frame_done) state_next = HOLD;
            HOLD:  if (out_ready)  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: in_ready  = 1'b1;
            HOLD:  out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Digit j lands at bit WIDTH-1-j; count never exceeds DIGITS-1 on an accept.
    assign shamt    = 32'(WIDTH - 1) - 32'(count);
    assign bit_mask = {{WIDTH{1'b0}}, 1'b1} << shamt;

    // On-the-fly update: only OR-ing a single new bit, never a carry chain.
    always_comb begin
        q_next  = q;
        qm_next = qm;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_digit[c].plus && !in_digit[c].minus) begin
                q_next[c]  = q[c] | bit_mask;
                qm_next[c] = q[c];
            end else if (!in_digit[c].plus && in_digit[c].minus) begin
                q_next[c]  = qm[c] | bit_mask;
                qm_next[c] = qm[c];
            end else begin
                q_next[c]  = q[c];
                qm_next[c] = qm[c] | bit_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reinit) begin
            for (int c = 0; c < CHANNELS; c++) begin
                q[c]  <= '0;
                qm[c] <= QM_INIT;
            end
            count <= '0;
        end else if (accept) begin
            q     <= q_next;
            qm    <= qm_next;
            count <= count + CW'(1);
        end
    end

    assign out_q     = q;
    assign out_qm    = qm;
    assign out_count = count;

endmodule

// File: tb/tb_otfc_conv_multi.sv
// tb/tb_otfc_conv_multi.sv - self-checking bench for otfc_conv_multi
module tb_otfc_conv_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Small instance: WIDTH=4, DIGITS=4, CHANNELS=2
    logic             s_rst, s_clear, s_in_valid, s_in_ready, s_in_last;
    logic             s_out_valid, s_out_ready;
    logic [1:0][1:0]  s_in_digit;
    logic [1:0][4:0]  s_out_q, s_out_qm;
    logic [2:0]       s_out_count;

    otfc_conv_multi #(.WIDTH(4), .DIGITS(4), .CHANNELS(2)) u_small (
        .clk(clk), .rst(s_rst), .clear(s_clear),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_digit(s_in_digit), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_q(s_out_q), .out_qm(s_out_qm), .out_count(s_out_count)
    );

    // Large instance: WIDTH=16, DIGITS=12, CHANNELS=4
    logic             b_rst, b_clear, b_in_valid, b_in_ready, b_in_last;
    logic             b_out_valid, b_out_ready;
    logic [3:0][1:0]  b_in_digit;
    logic [3:0][16:0] b_out_q, b_out_qm;
    logic [3:0]       b_out_count;

    otfc_conv_multi #(.WIDTH(16), .DIGITS(12), .CHANNELS(4)) u_big (
        .clk(clk), .rst(b_rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_digit(b_in_digit), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_q(b_out_q), .out_qm(b_out_qm), .out_count(b_out_count)
    );

    localparam logic [1:0] DP = 2'b10;  // +1
    localparam logic [1:0] DN = 2'b01;  // -1
    localparam logic [1:0] DZ = 2'b00;  // 0
    localparam logic [1:0] DB = 2'b11;  // both set = 0

    task automatic s_send(input logic [1:0] d0, input logic [1:0] d1, input logic last);
        s_in_digit = {d1, d0};
        s_in_last  = last;
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    task automatic s_drain();
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    int             v[4];
    int             len;
    logic           use_last;
    logic [7:0]     rdig;
    logic [16:0]    eq, eqm, held_q;
    logic [4:0]     held_s;

    initial begin
        s_rst = 1'b1; s_clear = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0;
        s_out_ready = 1'b0; s_in_digit = '0;
        b_rst = 1'b1; b_clear = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0;
        b_out_ready = 1'b0; b_in_digit = '0;
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", s_in_ready, 1);
        check("rst_out_valid", s_out_valid, 0);
        check("rst_q", s_out_q[0], 5'b00000);
        check("rst_qm", s_out_qm[1], 5'b10000);
        check("rst_count", s_out_count, 0);
        check("rst_big_qm", b_out_qm[3], 17'h10000);
        check("rst_big_ready", b_in_ready, 1);

        // 1: +1,0,-1,+1 on lane0
        @(posedge clk); #1;
        s_send(DP, DZ, 0);
        s_send(DZ, DZ, 0);
        s_send(DN, DZ, 0);
        @(negedge clk);
        check("t1_not_yet_valid", s_out_valid, 0);
        check("t1_count3", s_out_count, 3);
        s_send(DP, DZ, 0);
        @(negedge clk);
        check("t1_valid", s_out_valid, 1);
        check("t1_q0", s_out_q[0], 5'b00111);
        check("t1_qm0", s_out_qm[0], 5'b00110);
        check("t1_count", s_out_count, 4);
        check("t1_q1", s_out_q[1], 5'b00000);
        check("t1_qm1", s_out_qm[1], 5'b11111);
        s_drain();

        // 2: lane1 all -1, lane0 all both-set
        for (int i = 0; i < 4; i++) s_send(DB, DN, 0);
        @(negedge clk);
        check("t2_valid", s_out_valid, 1);
        check("t2_q1", s_out_q[1], 5'b10001);
        check("t2_qm1", s_out_qm[1], 5'b10000);
        check("t2_q0", s_out_q[0], 5'b00000);
        check("t2_qm0", s_out_qm[0], 5'b11111);
        s_drain();

        // 3: early termination
        s_send(DN, DN, 0);
        s_send(DN, DN, 1);
        @(negedge clk);
        check("t3_valid", s_out_valid, 1);
        check("t3_q0", s_out_q[0], 5'b10100);
        check("t3_qm0", s_out_qm[0], 5'b10000);
        check("t3_count", s_out_count, 2);
        check("t3_in_ready", s_in_ready, 0);

        // 4: back-pressure in HOLD with a digit offered
        s_in_valid = 1'b1;
        s_in_digit = {DP, DP};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", s_out_valid, 1);
            check("t4_hold_q", s_out_q[0], 5'b10100);
            check("t4_hold_count", s_out_count, 2);
        end
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        @(negedge clk);
        check("t4_ready_after", s_in_ready, 1);
        check("t4_valid_after", s_out_valid, 0);
        check("t4_q_after", s_out_q[0], 5'b00000);
        check("t4_qm_after", s_out_qm[0], 5'b10000);
        check("t4_count_after", s_out_count, 0);

        // 5: clear then rst mid-frame with a concurrent digit
        @(posedge clk); #1;
        s_send(DP, DP, 0);
        s_send(DP, DP, 0);
        s_clear = 1'b1; s_in_valid = 1'b1; s_in_digit = {DP, DP};
        @(posedge clk); #1;
        s_clear = 1'b0; s_in_valid = 1'b0;
        @(negedge clk);
        check("t5_clr_count", s_out_count, 0);
        check("t5_clr_q", s_out_q[0], 5'b00000);
        check("t5_clr_qm", s_out_qm[0], 5'b10000);
        @(posedge clk); #1;
        s_send(DN, DN, 0);
        s_send(DN, DN, 0);
        s_send(DN, DN, 0);
        s_rst = 1'b1; s_in_valid = 1'b1; s_in_last = 1'b1; s_in_digit = {DN, DN};
        @(posedge clk); #1;
        s_rst = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_rst_no_valid", s_out_valid, 0);
            check("t5_rst_count", s_out_count, 0);
            check("t5_rst_q", s_out_q[1], 5'b00000);
        end
        held_s = s_out_qm[1];
        check("t5_rst_qm", held_s, 5'b10000);

        // 6: randomized frames on the large instance
        @(posedge clk); #1;
        for (int f = 0; f < 40; f++) begin
            len      = int'($urandom_range(1, 12));
            use_last = (len < 12) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int c = 0; c < 4; c++) v[c] = 0;
            for (int j = 0; j < len; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    b_in_valid = 1'b0;
                    b_in_last  = 1'($urandom_range(0, 1));
                    b_in_digit = 8'($urandom);
                    @(posedge clk); #1;
                end
                rdig = 8'($urandom);
                b_in_digit = rdig;
                for (int c = 0; c < 4; c++) begin
                    if (rdig[2*c+1] && !rdig[2*c])      v[c] += (1 << (15 - j));
                    else if (!rdig[2*c+1] && rdig[2*c]) v[c] -= (1 << (15 - j));
                end
                b_in_last  = (j == len - 1) && use_last;
                b_in_valid = 1'b1;
                check("r_in_ready", b_in_ready, 1);
                @(posedge clk); #1;
                b_in_valid = 1'b0;
                b_in_last  = 1'b0;
            end
            @(negedge clk);
            check("r_valid", b_out_valid, 1);
            check("r_count", b_out_count, len);
            for (int c = 0; c < 4; c++) begin
                eq  = v[c][16:0];
                v[c] = v[c] - (1 << (16 - len));
                eqm = v[c][16:0];
                check("r_q", b_out_q[c], eq);
                check("r_qm", b_out_qm[c], eqm);
            end
            held_q = b_out_q[0];
            repeat ($urandom_range(0, 3)) begin
                b_in_valid = 1'b1;
                b_in_digit = 8'($urandom);
                @(posedge clk);
                @(negedge clk);
                check("r_bp_valid", b_out_valid, 1);
                check("r_bp_q", b_out_q[0], held_q);
                check("r_bp_count", b_out_count, len);
            end
            b_in_valid  = 1'b0;
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
            @(negedge clk);
            check("r_reinit_valid", b_out_valid, 0);
            check("r_reinit_count", b_out_count, 0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
